// File: rtl/program_loader_pkg.sv
// Shared pipeline package for the program loader.
// Holds the instruction-memory geometry used by the fetch stage and the
// loader FSM state encoding, plus a small helper that tells which states
// accept stream bytes.
package program_loader_pkg;

  // Word-address width of the instruction memory (matches the fetch PC).
  localparam int IMEM_ADDR_W = 11;
  // Largest loadable program, in 32-bit words.
  localparam int IMEM_DEPTH  = 2048;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LEN_LO = 3'd1,
    ST_LEN_HI = 3'd2,
    ST_DATA   = 3'd3,
    ST_WRITE  = 3'd4,
    ST_DONE   = 3'd5,
    ST_ERROR  = 3'd6
  } state_t;

  // States in which the loader consumes bytes from the stream.
  function automatic logic takes_bytes(input state_t s);
    return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA);
  endfunction

endpackage

// File: rtl/byte_assembler.sv
// byte_assembler: gathers four little-endian bytes into one 32-bit word.
// Ports:
//   clock      system clock, rising edge
//   reset      synchronous active-low reset, clears the lane index
//   clr        clears the lane index (new load starting)
//   load       byte_in is written into the current lane, index advances mod 4
//   byte_in    incoming stream byte
//   last       current lane is lane 3 (the next load completes a word)
//   word_next  stored lanes with byte_in placed in the current lane, i.e.
//              the word as it will look once this byte is loaded
module byte_assembler (
  input  logic        clock,
  input  logic        reset,
  input  logic        clr,
  input  logic        load,
  input  logic [7:0]  byte_in,
  output logic        last,
  output logic [31:0] word_next
);

  logic [1:0]  idx_q, idx_d;
  logic [31:0] word_q, word_d;

  always_comb begin
    idx_d  = idx_q;
    word_d = word_q;
    if (clr) begin
      idx_d = 2'd0;
    end else if (load) begin
      word_d[{idx_q, 3'b000} +: 8] = byte_in;
      idx_d                        = idx_q + 2'd1;
    end
  end

  // Lets the owner capture a completed word in the same edge that accepts
  // its fourth byte, so the write strobe follows one cycle later.
  always_comb begin
    word_next                        = word_q;
    word_next[{idx_q, 3'b000} +: 8]  = byte_in;
  end

  assign last = (idx_q == 2'd3);

  always_ff @(posedge clock) begin
    if (!reset) begin
      idx_q <= 2'd0;
    end else begin
      idx_q <= idx_d;
    end
  end

  // Lane storage carries data only; a stale word is never written because
  // the index restarts at lane 0 on every new load.
  always_ff @(posedge clock) begin
    word_q <= word_d;
  end

endmodule

// File: rtl/program_loader.sv
// program_loader: receives a byte-serial program image and writes it into
// instruction memory while holding the pipeline stalled.
// Stream: count_lo, count_hi (16-bit word count), then count words of four
// little-endian bytes each.
// Ports:
//   clock          system clock, rising edge
//   reset          synchronous active-low reset
//   start          one-cycle pulse that begins a load (from IDLE/DONE/ERROR)
//   byte_in        stream byte
//   byte_valid     byte_in is valid
//   byte_ready     loader accepts a byte this cycle
//   imem_we        one-cycle write strobe per assembled word
//   imem_addr      word address of the write (holds between writes)
//   imem_data      word to write (holds between writes)
//   pipeline_hold  low only once a load has completed
//   done           level, load completed
//   error          level, word count exceeded memory depth
module program_loader #(
  parameter int IMEM_ADDR_W = program_loader_pkg::IMEM_ADDR_W,
  parameter int IMEM_DEPTH  = program_loader_pkg::IMEM_DEPTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [7:0]             byte_in,
  input  logic                   byte_valid,
  output logic                   byte_ready,
  output logic                   imem_we,
  output logic [IMEM_ADDR_W-1:0] imem_addr,
  output logic [31:0]            imem_data,
  output logic                   pipeline_hold,
  output logic                   done,
  output logic                   error
);

  import program_loader_pkg::*;

  localparam logic [16:0] DEPTH_17 = 17'(IMEM_DEPTH);

  state_t                 state_q, state_d;
  logic [15:0]            count_q, count_d;
  logic [IMEM_ADDR_W:0]   widx_q, widx_d;

  logic                   byte_ready_q, byte_ready_d;
  logic                   imem_we_q, imem_we_d;
  logic [IMEM_ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]            imem_data_q, imem_data_d;
  logic                   hold_q, hold_d;
  logic                   done_q, done_d;
  logic                   error_q, error_d;

  logic                   fire;
  logic [15:0]            len16;
  logic [16:0]            written_cnt;
  logic                   asm_clr, asm_load, asm_last;
  logic [31:0]            asm_word_next;

  byte_assembler u_byte_assembler (
    .clock     (clock),
    .reset     (reset),
    .clr       (asm_clr),
    .load      (asm_load),
    .byte_in   (byte_in),
    .last      (asm_last),
    .word_next (asm_word_next)
  );

  // byte_ready_q is registered from the next state, so it already equals
  // "current state accepts bytes".
  assign fire        = byte_valid && byte_ready_q;
  assign len16       = {byte_in, count_q[7:0]};
  // Number of words written once the current WRITE completes; 17 bits so a
  // full-depth load compares against the 16-bit count without wrap.
  assign written_cnt = 17'(widx_q) + 17'd1;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    widx_d   = widx_q;
    asm_clr  = 1'b0;
    asm_load = 1'b0;

    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_d = ST_LEN_LO;
          count_d = 16'd0;
          widx_d  = '0;
          asm_clr = 1'b1;
        end
      end
      ST_LEN_LO: begin
        if (fire) begin
          count_d[7:0] = byte_in;
          state_d      = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (fire) begin
          count_d = len16;
          if (len16 == 16'd0) begin
            state_d = ST_DONE;
          end else if (17'(len16) > DEPTH_17) begin
            state_d = ST_ERROR;
          end else begin
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (fire) begin
          asm_load = 1'b1;
          if (asm_last) begin
            state_d = ST_WRITE;
          end
        end
      end
      ST_WRITE: begin
        widx_d = widx_q + 1'b1;
        if (written_cnt == {1'b0, count_q}) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DATA;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up exactly with
  // the state they describe.
  always_comb begin
    byte_ready_d = takes_bytes(state_d);
    imem_we_d    = (state_d == ST_WRITE);
    imem_addr_d  = imem_addr_q;
    imem_data_d  = imem_data_q;
    hold_d       = (state_d != ST_DONE);
    done_d       = (state_d == ST_DONE);
    error_d      = (state_d == ST_ERROR);
    // WRITE is only entered from DATA on the fourth byte, so widx_q is the
    // address of the word being completed.
    if (state_d == ST_WRITE) begin
      imem_addr_d = widx_q[IMEM_ADDR_W-1:0];
      imem_data_d = asm_word_next;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      count_q      <= 16'd0;
      widx_q       <= '0;
      byte_ready_q <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_data_q  <= 32'd0;
      hold_q       <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      widx_q       <= widx_d;
      byte_ready_q <= byte_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_data_q  <= imem_data_d;
      hold_q       <= hold_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  assign byte_ready    = byte_ready_q;
  assign imem_we       = imem_we_q;
  assign imem_addr     = imem_addr_q;
  assign imem_data     = imem_data_q;
  assign pipeline_hold = hold_q;
  assign done          = done_q;
  assign error         = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: expected memory writes are queued
// as words are sent; a negedge monitor pops and compares every imem_we.
module tb_program_loader;

  localparam int AW    = 11;
  localparam int DEPTH = 2048;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  logic          clock;
  logic          reset;
  logic          start;
  logic [7:0]    byte_in;
  logic          byte_valid;
  logic          byte_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_data;
  logic          pipeline_hold;
  logic          done;
  logic          error;

  wr_t           exp_q[$];
  int            vectors;
  int            miscompares;
  int            writes_seen;
  bit            rand_gaps;
  logic [31:0]   mem [0:DEPTH-1];
  logic [31:0]   ew  [0:DEPTH-1];

  program_loader #(.IMEM_ADDR_W(AW), .IMEM_DEPTH(DEPTH)) dut (
    .clock         (clock),
    .reset         (reset),
    .start         (start),
    .byte_in       (byte_in),
    .byte_valid    (byte_valid),
    .byte_ready    (byte_ready),
    .imem_we       (imem_we),
    .imem_addr     (imem_addr),
    .imem_data     (imem_data),
    .pipeline_hold (pipeline_hold),
    .done          (done),
    .error         (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the oldest queued write.
  initial begin
    wr_t e;
    writes_seen = 0;
    forever begin
      @(negedge clock);
      if (imem_we === 1'b1) begin
        writes_seen++;
        mem[imem_addr] = imem_data;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_write: addr %h data %h, required no write", imem_addr, imem_data);
        end else begin
          e = exp_q.pop_front();
          check("write_addr", 32'(imem_addr), 32'(e.addr));
          check("write_data", imem_data, e.data);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Offers one byte and returns #1 after the edge that accepted it.
  task automatic send_byte(input logic [7:0] b);
    int  n;
    bit  ok;
    n  = 0;
    ok = 1'b0;
    if (rand_gaps) begin
      byte_valid = 1'b0;
      repeat ($urandom_range(0, 2)) tick();
    end
    byte_in    = b;
    byte_valid = 1'b1;
    while (!ok && n < 200) begin
      ok = byte_ready;
      tick();
      n++;
    end
    if (!ok) check("byte_accept_timeout", 32'd0, 32'd1);
    byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [AW-1:0] addr, input logic [31:0] w);
    exp_q.push_back('{addr: addr, data: w});
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    check("we_after_4th_byte", 32'(imem_we), 32'd1);
  endtask

  task automatic wait_end(input string name, input logic exp_done, input logic exp_error);
    int n;
    n = 0;
    while (!(done || error) && n < 30) begin
      tick();
      n++;
    end
    check({name, "_done"}, 32'(done), 32'(exp_done));
    check({name, "_error"}, 32'(error), 32'(exp_error));
    check({name, "_hold"}, 32'(pipeline_hold), 32'(!exp_done));
    check({name, "_byte_ready"}, 32'(byte_ready), 32'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_byte_ready"}, 32'(byte_ready), 32'd0);
    check({name, "_we"}, 32'(imem_we), 32'd0);
    check({name, "_addr"}, 32'(imem_addr), 32'd0);
    check({name, "_data"}, imem_data, 32'd0);
    check({name, "_hold"}, 32'(pipeline_hold), 32'd1);
    check({name, "_done"}, 32'(done), 32'd0);
    check({name, "_error"}, 32'(error), 32'd0);
  endtask

  initial begin
    int w0;
    int bad;
    vectors     = 0;
    miscompares = 0;
    rand_gaps   = 1'b0;
    reset       = 1'b0;
    start       = 1'b0;
    byte_in     = 8'h00;
    byte_valid  = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    reset = 1'b1;
    tick();
    check("idle_byte_ready", 32'(byte_ready), 32'd0);

    // Two-word load.
    pulse_start();
    check("len_lo_byte_ready", 32'(byte_ready), 32'd1);
    send_byte(8'h02);
    send_byte(8'h00);
    send_word(11'd0, 32'h0000_0013);
    send_word(11'd1, 32'h0008_0020);
    wait_end("two_words", 1'b1, 1'b0);

    // Zero count: DONE right after count_hi, no write.
    pulse_start();
    check("restart_done_cleared", 32'(done), 32'd0);
    check("restart_hold", 32'(pipeline_hold), 32'd1);
    w0 = writes_seen;
    send_byte(8'h00);
    send_byte(8'h00);
    check("count0_done_latency", 32'(done), 32'd1);
    check("count0_hold", 32'(pipeline_hold), 32'd0);
    repeat (3) tick();
    check("count0_no_write", 32'(writes_seen - w0), 32'd0);

    // Oversize count: error, then a normal load clears it.
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h08);
    wait_end("oversize", 1'b0, 1'b1);
    repeat (3) tick();
    check("oversize_no_write", 32'(writes_seen - w0), 32'd0);
    pulse_start();
    check("error_cleared_on_start", 32'(error), 32'd0);
    send_byte(8'h01);
    send_byte(8'h00);
    send_word(11'd0, 32'hDEAD_BEEF);
    wait_end("after_error", 1'b1, 1'b0);

    // Start pulsed mid-load is ignored.
    pulse_start();
    send_byte(8'h02);
    pulse_start();
    send_byte(8'h00);
    send_word(11'd0, 32'hCAFE_F00D);
    exp_q.push_back('{addr: 11'd1, data: 32'h1234_5678});
    send_byte(8'h78);
    send_byte(8'h56);
    pulse_start();
    send_byte(8'h34);
    send_byte(8'h12);
    check("midstart_we", 32'(imem_we), 32'd1);
    wait_end("midstart", 1'b1, 1'b0);

    // Reset after byte 5 (first byte of word 1), random valid gaps.
    rand_gaps = 1'b1;
    pulse_start();
    send_byte(8'h03);
    send_byte(8'h00);
    send_word(11'd0, 32'hA5A5_0F0F);
    send_byte(8'h11);
    reset = 1'b0;
    tick();
    check_reset_outputs("midload_reset");
    reset = 1'b1;
    w0 = writes_seen;
    byte_in    = 8'h22;
    byte_valid = 1'b1;
    repeat (6) tick();
    byte_valid = 1'b0;
    check("post_reset_no_write", 32'(writes_seen - w0), 32'd0);
    check("post_reset_idle_ready", 32'(byte_ready), 32'd0);
    pulse_start();
    send_byte(8'h01);
    send_byte(8'h00);
    send_word(11'd0, 32'h0BAD_F00D);
    wait_end("reload", 1'b1, 1'b0);

    // Full-depth load.
    pulse_start();
    send_byte(8'h00);
    send_byte(8'h08);
    w0 = writes_seen;
    for (int i = 0; i < DEPTH; i++) begin
      ew[i] = $urandom;
      send_word(AW'(i), ew[i]);
    end
    wait_end("full_depth", 1'b1, 1'b0);
    check("full_depth_write_count", 32'(writes_seen - w0), 32'(DEPTH));
    check("full_depth_last_addr", 32'(imem_addr), 32'h7FF);
    bad = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (mem[i] !== ew[i]) bad++;
    end
    check("full_depth_readback_errors", 32'(bad), 32'd0);

    repeat (4) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 Parameter IMEM_ADDR_W, default 11, instruction-memory word-address width matching the fetch-stage PC.
REQ-002 Parameter IMEM_DEPTH, default 2048, maximum loadable word count (2**IMEM_ADDR_W).
REQ-003 clock  input  1  single system clock; all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-low reset (0 = reset).
REQ-005 start  input  1  one-cycle pulse; begins a program load.
REQ-006 byte_in  input  8  serial program byte stream.
REQ-007 byte_valid  input  1  byte_in holds a valid byte.
REQ-008 byte_ready  output  1  loader accepts a byte this cycle; transfer occurs when byte_valid && byte_ready.
REQ-009 imem_we  output  1  instruction-memory write strobe, one cycle per word.
REQ-010 imem_addr  output  IMEM_ADDR_W  instruction-memory word address.
REQ-011 imem_data  output  32  instruction word to write.
REQ-012 pipeline_hold  output  1  keeps the pipeline stalled and PC at 0 while high.
REQ-013 done  output  1  load completed; level, high until the next start.
REQ-014 error  output  1  load rejected; level, high until the next start.

Function
REQ-015 Stream format SHALL be: count_lo, count_hi (16-bit word count, little-endian), then count words of 4 bytes each, little-endian (first byte = bits 7:0).
REQ-016 FSM states SHALL be IDLE, LEN_LO, LEN_HI, DATA, WRITE, DONE, ERROR.
REQ-017 IDLE, DONE, ERROR -> LEN_LO on start; start SHALL be ignored in LEN_LO, LEN_HI, DATA and WRITE.
REQ-018 LEN_LO -> LEN_HI on an accepted byte; LEN_HI -> DATA on an accepted byte if 1 <= count <= IMEM_DEPTH, -> DONE if count == 0, -> ERROR if count > IMEM_DEPTH.
REQ-019 byte_ready SHALL be 1 exactly in LEN_LO, LEN_HI and DATA, 0 in all other states.
REQ-020 DATA SHALL hold a 2-bit byte index; each accepted byte loads into lane index, index increments mod 4; on the 4th byte -> WRITE.
REQ-021 WRITE SHALL last exactly one cycle with imem_we=1, imem_data = assembled word, imem_addr = current word index; i.e. imem_we rises the cycle after the 4th byte is accepted.
REQ-022 In WRITE the word index (IMEM_ADDR_W+1 bits) SHALL increment; if the written word was count-1 -> DONE, else -> DATA.
REQ-023 imem_we SHALL be 0 outside WRITE; imem_addr and imem_data SHALL hold their last values outside WRITE.
REQ-024 Word index and byte index SHALL clear to 0 on every entry into LEN_LO.
REQ-025 count == IMEM_DEPTH SHALL write addresses 0..IMEM_DEPTH-1 with no wrap to address 0.
REQ-026 pipeline_hold SHALL be 0 only in DONE; 1 in every other state, including ERROR.
REQ-027 done SHALL be 1 only in DONE, error only in ERROR; both 0 in LEN_LO, LEN_HI, DATA and WRITE.
REQ-028 byte_valid low in LEN_LO, LEN_HI or DATA SHALL stall the FSM indefinitely with no state change.

Reset
REQ-029 reset low at any edge, including mid-load, SHALL force IDLE, byte_ready=0, imem_we=0, imem_addr=0, imem_data=0, pipeline_hold=1, done=0, error=0, and clear both indices and the count.
REQ-030 A partially written memory image after reset mid-load SHALL be left as is; completion is indicated only by done.

Structure
REQ-031 FSM state encoding, IMEM_ADDR_W and IMEM_DEPTH SHALL live in the shared pipeline package.
REQ-032 One sub-module, byte_assembler (4-lane byte-to-word shift register with index), SHALL be used; the FSM stays in program_loader.

Verification
REQ-033 Count 2, bytes 0x13,0x00,0x00,0x00,0x20,0x00,0x08,0x00 -> writes addr0=0x00000013, addr1=0x00080020, then done=1, pipeline_hold=0.
REQ-034 Count 0 (0x00,0x00) -> DONE the cycle after count_hi is accepted, no imem_we pulse.
REQ-035 Count 0x0801 -> error=1, pipeline_hold=1, no writes; subsequent start with count 1 -> normal load, error=0.
REQ-036 Count 2048 with random words -> 2048 imem_we pulses, last addr 0x7FF, memory readback matches.
REQ-037 byte_valid toggled randomly and reset asserted after byte 5 of word 1 -> no further writes, outputs at reset values; reload succeeds.
REQ-038 start pulsed mid-load -> ignored; load completes unchanged.
